// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared constants, state enum and read-tag type for the frame-buffer scheduler
package vga_pkg;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} sched_state_t;

    localparam logic SRC_LB   = 1'b0;
    localparam logic SRC_CONV = 1'b1;

    typedef struct packed {
        logic valid;
        logic src;
    } rd_tag_t;

    // An aborted burst kills only line-buffer tags; conv reads still return to conv.
    function automatic rd_tag_t flush_lb(rd_tag_t t, logic flush);
        rd_tag_t r;
        r = t;
        if (flush && t.src == SRC_LB) r.valid = 1'b0;
        return r;
    endfunction
endpackage

// File: rtl/vga_rd_tag_pipe.sv
// rtl/vga_rd_tag_pipe.sv - RD_LAT-deep shift register of read tags, aligned to mem_rvalid
module vga_rd_tag_pipe
    import vga_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic    i_clk,
    input  logic    i_reset,
    input  logic    i_flush,
    input  rd_tag_t i_push,
    output rd_tag_t o_tag
);
    rd_tag_t r_pipe [RD_LAT];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < RD_LAT; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= flush_lb(i_push, i_flush);
            for (int i = 1; i < RD_LAT; i++) r_pipe[i] <= flush_lb(r_pipe[i-1], i_flush);
        end
    end

    assign o_tag = r_pipe[RD_LAT-1];
endmodule

// File: rtl/vga_fb_scheduler.sv
// rtl/vga_fb_scheduler.sv - arbitrates frame memory between line prefetch (priority) and conv engine
module vga_fb_scheduler
    import vga_pkg::*;
#(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_line_start,
    input  logic [9:0]        i_fetch_line,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic              i_mem_ready,
    input  logic              i_mem_rvalid,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_lb_we,
    output logic              o_lb_bank,
    output logic [9:0]        o_lb_waddr,
    output logic [DATA_W-1:0] o_lb_wdata,
    input  logic              i_conv_req,
    input  logic              i_conv_we,
    input  logic [ADDR_W-1:0] i_conv_addr,
    input  logic [DATA_W-1:0] i_conv_wdata,
    output logic              o_conv_gnt,
    output logic              o_conv_rvalid,
    output logic [DATA_W-1:0] o_conv_rdata,
    output logic              o_fetch_busy,
    output logic              o_underrun
);
    localparam logic [9:0] LAST_IDX = 10'(H_ACTIVE - 1);

    sched_state_t      r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_base;
    logic [9:0]        r_issue_cnt;
    logic [9:0]        r_fill_cnt;
    logic              r_lb_bank;
    logic              r_underrun;

    logic [ADDR_W-1:0] w_base;
    logic              w_start, w_abort, w_final, w_tag_lb, w_accept;
    rd_tag_t           w_push, w_tag_out;

    assign w_base = ADDR_W'(i_fetch_line) * ADDR_W'(H_ACTIVE);

    vga_rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_flush (w_abort),
        .i_push  (w_push),
        .o_tag   (w_tag_out)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_tag_lb      = w_tag_out.valid && (w_tag_out.src == SRC_LB) && i_mem_rvalid;
        w_final       = w_tag_lb && (r_fill_cnt == LAST_IDX);
        w_start       = i_line_start && (i_fetch_line < 10'(V_ACTIVE));
        // A start landing on the final fill write is a clean hand-over, not an overrun.
        w_abort       = w_start && (r_state != IDLE) && !(r_state == DRAIN && w_final);
        w_state_nxt   = r_state;
        o_fetch_busy  = (r_state != IDLE);
        o_mem_req     = i_conv_req;
        o_mem_we      = i_conv_we;
        o_mem_addr    = i_conv_addr;
        o_mem_wdata   = i_conv_wdata;
        o_conv_gnt    = i_conv_req && i_mem_ready;
        case (r_state)
            FETCH: begin
                o_mem_req   = 1'b1;
                o_mem_we    = 1'b0;
                o_mem_addr  = r_base + ADDR_W'(r_issue_cnt);
                o_mem_wdata = '0;
                o_conv_gnt  = 1'b0;
                if (i_mem_ready && r_issue_cnt == LAST_IDX) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (w_final) w_state_nxt = IDLE;
            end
            default: ;
        endcase
        if (w_start) w_state_nxt = FETCH;
        w_accept      = o_mem_req && i_mem_ready;
        w_push        = '0;
        w_push.valid  = w_accept && !o_mem_we;
        w_push.src    = (r_state == FETCH) ? SRC_LB : SRC_CONV;
        o_lb_we       = w_tag_lb && !w_abort;
        o_conv_rvalid = w_tag_out.valid && (w_tag_out.src == SRC_CONV) && i_mem_rvalid;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_base      <= '0;
            r_issue_cnt <= '0;
            r_fill_cnt  <= '0;
            r_lb_bank   <= 1'b0;
            r_underrun  <= 1'b0;
        end else if (w_start) begin
            r_base      <= w_base;
            r_lb_bank   <= ~r_lb_bank;
            r_issue_cnt <= '0;
            r_fill_cnt  <= '0;
            if (w_abort) r_underrun <= 1'b1;
        end else begin
            if (r_state == FETCH && i_mem_ready) r_issue_cnt <= r_issue_cnt + 10'd1;
            if (o_lb_we) r_fill_cnt <= r_fill_cnt + 10'd1;
        end
    end

    assign o_lb_bank    = r_lb_bank;
    assign o_lb_waddr   = r_fill_cnt;
    assign o_lb_wdata   = i_mem_rdata;
    assign o_conv_rdata = i_mem_rdata;
    assign o_underrun   = r_underrun;
endmodule

// File: tb/tb_vga_fb_scheduler.sv
// tb/tb_vga_fb_scheduler.sv - directed/randomized bench with memory model and burst reference
module tb_vga_fb_scheduler;
    import vga_pkg::*;
    localparam int ADDR_W = 19;
    localparam int DATA_W = 8;
    localparam int RD_LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset = 1'b1;
    logic              line_start = 1'b0;
    logic [9:0]        fetch_line = '0;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready = 1'b1;
    logic              mem_rvalid = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              lb_we, lb_bank;
    logic [9:0]        lb_waddr;
    logic [DATA_W-1:0] lb_wdata;
    logic              conv_req = 1'b0, conv_we = 1'b0;
    logic [ADDR_W-1:0] conv_addr = '0;
    logic [DATA_W-1:0] conv_wdata = '0;
    logic              conv_gnt, conv_rvalid;
    logic [DATA_W-1:0] conv_rdata;
    logic              fetch_busy, underrun;

    vga_fb_scheduler #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .i_clk(clk), .i_reset(reset), .i_line_start(line_start), .i_fetch_line(fetch_line),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_ready(mem_ready), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
        .o_lb_we(lb_we), .o_lb_bank(lb_bank), .o_lb_waddr(lb_waddr), .o_lb_wdata(lb_wdata),
        .i_conv_req(conv_req), .i_conv_we(conv_we), .i_conv_addr(conv_addr), .i_conv_wdata(conv_wdata),
        .o_conv_gnt(conv_gnt), .o_conv_rvalid(conv_rvalid), .o_conv_rdata(conv_rdata),
        .o_fetch_busy(fetch_busy), .o_underrun(underrun)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mem_w [int];
    function automatic logic [7:0] rd(int a);
        if (mem_w.exists(a)) return mem_w[a];
        return 8'((a * 13) ^ (a >> 7) ^ 8'h5a);
    endfunction

    int gen = 0, seen_gen = 0, cyc = 0;
    logic rmode = 1'b0;
    int q_iss[$], q_iss_cyc[$], q_lb_addr[$];
    logic [7:0] q_lb_data[$], q_crd[$];
    logic q_lb_bank[$];
    int n_gnt = 0, gnt_cyc = -1, crv_cyc = -1, last_lb_cyc = -1, busy_fall_cyc = -1;
    logic prev_busy = 1'b0;
    logic mp_v [RD_LAT] = '{default: 1'b0};
    logic [7:0] mp_d [RD_LAT] = '{default: 8'h00};

    always begin : mem_model
        logic acc_v;
        logic [7:0] acc_d;
        @(negedge clk);
        cyc++;
        if (gen != seen_gen) begin
            seen_gen = gen;
            q_iss.delete(); q_iss_cyc.delete(); q_lb_addr.delete();
            q_lb_data.delete(); q_lb_bank.delete(); q_crd.delete();
            n_gnt = 0; gnt_cyc = -1; crv_cyc = -1; last_lb_cyc = -1; busy_fall_cyc = -1;
        end
        acc_v = 1'b0;
        acc_d = '0;
        if (mem_req && mem_ready) begin
            if (mem_we) mem_w[int'(mem_addr)] = mem_wdata;
            else begin
                acc_v = 1'b1;
                acc_d = rd(int'(mem_addr));
            end
            if (conv_gnt) begin
                n_gnt++;
                gnt_cyc = cyc;
            end else if (!mem_we) begin
                q_iss.push_back(int'(mem_addr));
                q_iss_cyc.push_back(cyc);
            end
        end
        if (lb_we) begin
            q_lb_addr.push_back(int'(lb_waddr));
            q_lb_data.push_back(lb_wdata);
            q_lb_bank.push_back(lb_bank);
            last_lb_cyc = cyc;
        end
        if (conv_rvalid) begin
            crv_cyc = cyc;
            q_crd.push_back(conv_rdata);
        end
        if (prev_busy && !fetch_busy) busy_fall_cyc = cyc;
        prev_busy = fetch_busy;
        @(posedge clk);
        #1;
        for (int k = RD_LAT - 1; k > 0; k--) begin
            mp_v[k] = mp_v[k-1];
            mp_d[k] = mp_d[k-1];
        end
        mp_v[0] = acc_v;
        mp_d[0] = acc_d;
        mem_rvalid = mp_v[RD_LAT-1];
        mem_rdata  = mp_d[RD_LAT-1];
        mem_ready  = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        gen++;
        tick();
        tick();
    endtask

    task automatic start_line(input int l);
        tick();
        line_start = 1'b1;
        fetch_line = 10'(l);
        tick();
        line_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin
            tick();
            n++;
        end while (fetch_busy && n < budget);
        check("idle_timeout", 32'(n < budget), 1);
        repeat (RD_LAT + 2) tick();
    endtask

    task automatic conv_op(input logic we, input logic [ADDR_W-1:0] a, input logic [7:0] d);
        int g0 = n_gnt;
        int n = 0;
        conv_req = 1'b1; conv_we = we; conv_addr = a; conv_wdata = d;
        do begin
            tick();
            n++;
        end while (n_gnt == g0 && n < 3000);
        conv_req = 1'b0;
        check("gnt_timeout", 32'(n_gnt > g0), 1);
    endtask

    // Expected burst: addresses line*H_ACTIVE+i in order, line buffer gets word i at index i.
    task automatic verify(input int oi, input int ni, input int ol, input int nl,
                          input int line, input logic bank, input string tag);
        int bad_a = 0;
        int bad_l = 0;
        for (int i = 0; i < ni; i++)
            if (oi + i >= q_iss.size() || q_iss[oi+i] != line * H_ACTIVE + i) bad_a++;
        for (int i = 0; i < nl; i++) begin
            int j = ol + i;
            if (j >= q_lb_addr.size() || q_lb_addr[j] != i ||
                q_lb_data[j] !== rd(line * H_ACTIVE + i) || q_lb_bank[j] !== bank) bad_l++;
        end
        check({tag, "_addr_bad"}, bad_a, 0);
        check({tag, "_lb_bad"}, bad_l, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a_line, b_line, l, n;
        logic exp_bank, b1;
        logic [ADDR_W-1:0] ca;
        logic [7:0] cd;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_mem_req", mem_req, 0);
        check("rst_lb_we", lb_we, 0);
        check("rst_lb_bank", lb_bank, 0);
        check("rst_busy", fetch_busy, 0);
        check("rst_underrun", underrun, 0);
        check("rst_conv_gnt", conv_gnt, 0);
        check("rst_conv_rvalid", conv_rvalid, 0);
        exp_bank = 1'b0;

        clr();
        start_line(0);
        exp_bank = ~exp_bank;
        wait_idle(2000);
        check("l0_iss_n", q_iss.size(), H_ACTIVE);
        check("l0_lb_n", q_lb_addr.size(), H_ACTIVE);
        verify(0, H_ACTIVE, 0, H_ACTIVE, 0, exp_bank, "l0");
        check("l0_back_to_back", q_iss_cyc[H_ACTIVE-1] - q_iss_cyc[0], H_ACTIVE - 1);
        check("l0_bank", lb_bank, 1);
        check("l0_busy_fall", busy_fall_cyc, last_lb_cyc + 1);

        clr();
        start_line(479);
        exp_bank = ~exp_bank;
        wait_idle(2000);
        check("l479_first", q_iss[0], 306560);
        check("l479_last", q_iss[H_ACTIVE-1], 307199);
        verify(0, H_ACTIVE, 0, H_ACTIVE, 479, exp_bank, "l479");

        clr();
        start_line(500);
        repeat (20) tick();
        check("l500_no_req", q_iss.size(), 0);
        check("l500_bank", lb_bank, exp_bank);
        check("l500_busy", fetch_busy, 0);

        clr();
        l = $urandom_range(0, V_ACTIVE - 1);
        ca = 19'($urandom_range(310000, 524287));
        start_line(l);
        exp_bank = ~exp_bank;
        conv_op(1'b0, ca, 8'h00);
        wait_idle(3000);
        verify(0, H_ACTIVE, 0, H_ACTIVE, l, exp_bank, "conv_fetch");
        check("conv_gnt_n", n_gnt, 1);
        check("conv_gnt_at_drain", gnt_cyc, q_iss_cyc[H_ACTIVE-1] + 1);
        check("conv_rd_lat", crv_cyc, gnt_cyc + RD_LAT);
        check("conv_rdata", (q_crd.size() > 0) ? 32'(q_crd[0]) : 32'hdead, 32'(rd(int'(ca))));

        clr();
        cd = 8'($urandom);
        conv_op(1'b1, ca, cd);
        conv_op(1'b0, ca, 8'h00);
        repeat (RD_LAT + 2) tick();
        check("conv_wr_rd_n", q_crd.size(), 1);
        check("conv_wr_rd_data", (q_crd.size() > 0) ? 32'(q_crd[0]) : 32'hdead, 32'(cd));

        clr();
        rmode = 1'b1;
        l = $urandom_range(0, V_ACTIVE - 1);
        start_line(l);
        exp_bank = ~exp_bank;
        wait_idle(6000);
        rmode = 1'b0;
        check("rnd_iss_n", q_iss.size(), H_ACTIVE);
        check("rnd_lb_n", q_lb_addr.size(), H_ACTIVE);
        verify(0, H_ACTIVE, 0, H_ACTIVE, l, exp_bank, "rnd");

        clr();
        a_line = $urandom_range(0, V_ACTIVE - 1);
        b_line = $urandom_range(0, V_ACTIVE - 1);
        start_line(a_line);
        exp_bank = ~exp_bank;
        b1 = exp_bank;
        n = 0;
        while (q_lb_addr.size() < H_ACTIVE - 1 && n < 2000) begin
            tick();
            n++;
        end
        line_start = 1'b1;
        fetch_line = 10'(b_line);
        tick();
        line_start = 1'b0;
        exp_bank = ~exp_bank;
        wait_idle(2000);
        check("handover_underrun", underrun, 0);
        check("handover_iss_n", q_iss.size(), 2 * H_ACTIVE);
        check("handover_lb_n", q_lb_addr.size(), 2 * H_ACTIVE);
        verify(0, H_ACTIVE, 0, H_ACTIVE, a_line, b1, "handover_a");
        verify(H_ACTIVE, H_ACTIVE, H_ACTIVE, H_ACTIVE, b_line, exp_bank, "handover_b");

        clr();
        a_line = $urandom_range(0, V_ACTIVE - 1);
        b_line = (a_line + 1 + $urandom_range(0, V_ACTIVE - 2)) % V_ACTIVE;
        start_line(a_line);
        exp_bank = ~exp_bank;
        b1 = exp_bank;
        n = 0;
        while (q_iss.size() < 100 && n < 2000) begin
            tick();
            n++;
        end
        line_start = 1'b1;
        fetch_line = 10'(b_line);
        tick();
        line_start = 1'b0;
        exp_bank = ~exp_bank;
        wait_idle(2000);
        check("abort_underrun", underrun, 1);
        check("abort_iss_n", q_iss.size(), 101 + H_ACTIVE);
        check("abort_lb_n", q_lb_addr.size(), 100 - RD_LAT + H_ACTIVE);
        verify(0, 101, 0, 100 - RD_LAT, a_line, b1, "abort_old");
        verify(101, H_ACTIVE, 100 - RD_LAT, H_ACTIVE, b_line, exp_bank, "abort_new");
        check("abort_bank", lb_bank, exp_bank);
        start_line(0);
        exp_bank = ~exp_bank;
        wait_idle(2000);
        check("underrun_sticky", underrun, 1);

        clr();
        conv_op(1'b0, ca, 8'h00);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (RD_LAT + 3) tick();
        check("rst_drop_rvalid", q_crd.size(), 0);
        check("rst2_underrun", underrun, 0);
        check("rst2_bank", lb_bank, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
